craft_decrypt_core: RTL and testbench

//  Iterative CRAFT block-cipher decryptor: 64-bit ciphertext, 128-bit key, 64-bit tweak -> 64-bit plaintext.

---
 rtl/craft_decrypt_core_if.sv | 23 ++
 rtl/craft_decrypt_core.sv | 149 ++++++++++++++
 tb/tb_craft_decrypt_core.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/craft_decrypt_core_if.sv
// Stream interface of the CRAFT decryptor: job input (ct/key/tweak) and plaintext output.
// The master side is the job source/result sink; the slave side is the core.
interface craft_decrypt_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  ct;
    logic [127:0] key;
    logic [63:0]  tweak;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  pt;
    logic         busy;

    modport master (
        output in_valid, ct, key, tweak, out_ready,
        input  in_ready, out_valid, pt, busy
    );

    modport slave (
        input  in_valid, ct, key, tweak, out_ready,
        output in_ready, out_valid, pt, busy
    );
endinterface

// File: rtl/craft_decrypt_core.sv
// Iterative CRAFT decryptor: one inverse round per clock, rounds walked from NUM_ROUNDS-1 down to 0.
// Tweakeys and round constants are derived on the fly from the registered key, tweak and counter.
module craft_decrypt_core #(
    parameter int unsigned NUM_ROUNDS = 32
) (
    input logic                 clk,
    input logic                 rst,
    craft_decrypt_core_if.slave bus
);

    localparam logic [4:0]  LastRound = 5'(NUM_ROUNDS - 1);
    // Nibble j of each table holds the entry for index j (nibble 0 in the top bits).
    localparam logic [63:0] PermP     = 64'hFCDEA98B65471230;
    localparam logic [63:0] PermQ     = 64'hCAF5E892B374601D;
    localparam logic [63:0] SBox      = 64'hCAD3EBF789150246;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] x_q, x_d;
    logic [63:0] pt_q, pt_d;
    logic [63:0] k0_q, k1_q, t_q;
    logic        load;
    logic [63:0] tq, tk, rc_word, pre_mc, round_out;
    logic [7:0]  rc;

    function automatic logic [63:0] permute(input logic [63:0] x, input logic [63:0] tbl);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            y[63-4*j -: 4] = x[63-4*int'(tbl[63-4*j -: 4]) -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] sub_cells(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            y[63-4*j -: 4] = SBox[63-4*int'(x[63-4*j -: 4]) -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] mix_columns(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        for (int c = 0; c < 4; c++) begin
            y[63-4*c -: 4]     = x[63-4*c -: 4] ^ x[63-4*(c+8) -: 4] ^ x[63-4*(c+12) -: 4];
            y[63-4*(c+4) -: 4] = x[63-4*(c+4) -: 4] ^ x[63-4*(c+12) -: 4];
        end
        return y;
    endfunction

    // Round constants: 4-bit LFSR in the high nibble, 3-bit LFSR in the low nibble.
    function automatic logic [7:0] rc_lut(input logic [4:0] idx);
        logic [7:0] r;
        unique case (idx)
            5'd0:  r = 8'h11;  5'd1:  r = 8'h84;  5'd2:  r = 8'h42;  5'd3:  r = 8'h25;
            5'd4:  r = 8'h96;  5'd5:  r = 8'hC7;  5'd6:  r = 8'h63;  5'd7:  r = 8'hB1;
            5'd8:  r = 8'h54;  5'd9:  r = 8'hA2;  5'd10: r = 8'hD5;  5'd11: r = 8'hE6;
            5'd12: r = 8'hF7;  5'd13: r = 8'h73;  5'd14: r = 8'h31;  5'd15: r = 8'h14;
            5'd16: r = 8'h82;  5'd17: r = 8'h45;  5'd18: r = 8'h26;  5'd19: r = 8'h97;
            5'd20: r = 8'hC3;  5'd21: r = 8'h61;  5'd22: r = 8'hB4;  5'd23: r = 8'h52;
            5'd24: r = 8'hA5;  5'd25: r = 8'hD6;  5'd26: r = 8'hE7;  5'd27: r = 8'hF3;
            5'd28: r = 8'h71;  5'd29: r = 8'h34;  5'd30: r = 8'h12;  5'd31: r = 8'h85;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        tq = permute(t_q, PermQ);
        tk = '0;
        unique case (cnt_q[1:0])
            2'd0: tk = k0_q ^ t_q;
            2'd1: tk = k1_q ^ t_q;
            2'd2: tk = k0_q ^ tq;
            2'd3: tk = k1_q ^ tq;
            default: tk = '0;
        endcase
        rc      = rc_lut(cnt_q);
        rc_word = {16'h0000, rc, 40'h0};
        // The final encryption round has no S/P layer, so its inverse skips them too.
        pre_mc    = (cnt_q == LastRound) ? x_q : permute(sub_cells(x_q), PermP);
        round_out = mix_columns(pre_mc ^ tk ^ rc_word);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        pt_d    = pt_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    x_d     = bus.ct;
                    cnt_d   = LastRound;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d = round_out;
                if (cnt_q == 5'd0) begin
                    pt_d    = round_out;
                    cnt_d   = LastRound;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= LastRound;
            x_q     <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            pt_q    <= pt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            k0_q <= bus.key[127:64];
            k1_q <= bus.key[63:0];
            t_q  <= bus.tweak;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.pt        = pt_q;

endmodule

// File: tb/tb_craft_decrypt_core.sv
// Bench for craft_decrypt_core: plaintexts are encrypted by a nibble-level CRAFT model and the
// core must recover them; covers reset, latency, backpressure, streaming and reduced rounds.
module tb_craft_decrypt_core;

    localparam int PB [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int QB [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    localparam int SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    localparam int NumJobs = 100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    craft_decrypt_core_if bus32 ();
    craft_decrypt_core_if bus1 ();

    craft_decrypt_core #(.NUM_ROUNDS(32)) dut (.clk(clk), .rst(rst), .bus(bus32));
    craft_decrypt_core #(.NUM_ROUNDS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward CRAFT: per round MC, constants, tweakey, then P and S except in the last round.
    function automatic logic [63:0] craft_enc(input logic [63:0] p, input logic [127:0] key,
                                              input logic [63:0] tw, input int nr);
        logic [3:0]  s [16];
        logic [3:0]  tmp [16];
        logic [3:0]  tk [4][16];
        logic [3:0]  a;
        logic [2:0]  b;
        logic [63:0] y;
        for (int j = 0; j < 16; j++) begin
            s[j]     = p[63-4*j -: 4];
            tk[0][j] = key[127-4*j -: 4] ^ tw[63-4*j -: 4];
            tk[1][j] = key[63-4*j -: 4] ^ tw[63-4*j -: 4];
            tk[2][j] = key[127-4*j -: 4] ^ tw[63-4*QB[j] -: 4];
            tk[3][j] = key[63-4*j -: 4] ^ tw[63-4*QB[j] -: 4];
        end
        a = 4'h1;
        b = 3'h1;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < 4; c++) begin
                s[c]   = s[c] ^ s[c+8] ^ s[c+12];
                s[c+4] = s[c+4] ^ s[c+12];
            end
            s[4] = s[4] ^ a;
            s[5] = s[5] ^ {1'b0, b};
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ tk[r % 4][j];
            if (r != nr - 1) begin
                for (int j = 0; j < 16; j++) tmp[j] = s[PB[j]];
                for (int j = 0; j < 16; j++) s[j] = 4'(SB[int'(tmp[j])]);
            end
            a = {a[0] ^ a[1], a[3:1]};
            b = {b[0] ^ b[1], b[2:1]};
        end
        y = '0;
        for (int j = 0; j < 16; j++) y[63-4*j -: 4] = s[j];
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Presents one job to the 32-round core and waits (bounded) for out_valid.
    task automatic start_job32(input logic [63:0] c, input logic [127:0] k, input logic [63:0] t,
                               output int cyc, output logic busy_run, output logic rdy_run);
        @(negedge clk);
        bus32.ct       = c;
        bus32.key      = k;
        bus32.tweak    = t;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.ct       = rand64();
        bus32.key      = {rand64(), rand64()};
        busy_run       = bus32.busy;
        rdy_run        = bus32.in_ready;
        cyc            = 1;
        while (!bus32.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus32.in_ready, bus32.out_valid, bus32.busy);
        end
        checks++;
        if (bus32.pt !== 64'h0) begin
            errors++;
            $display("FAIL reset_pt got %h want 0", bus32.pt);
        end
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.pt !== 64'h0) begin
            errors++;
            $display("FAIL reset_dut1 got rdy=%b vld=%b pt=%h want 1 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.pt);
        end
        rst = 1'b0;
    endtask

    task automatic test_golden();
        logic [127:0] k;
        logic [63:0]  t, p, c;
        int           cyc;
        logic         bsy, rdy;
        k = 128'h27a6781a43f364bc916708d5fbb5aefe;
        t = 64'h54cd94ffd0670a58;
        p = 64'h5734f006d8d88a3e;
        c = craft_enc(p, k, t, 32);
        bus32.out_ready = 1'b1;
        start_job32(c, k, t, cyc, bsy, rdy);
        checks++;
        if (bus32.pt !== p) begin
            errors++;
            $display("FAIL golden_pt got %h want %h", bus32.pt, p);
        end
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL golden_latency got %0d want 33", cyc);
        end
        checks++;
        if (bsy !== 1'b1 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL golden_run_flags got busy=%b rdy=%b want 1 0", bsy, rdy);
        end
        @(negedge clk);
        checks++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.pt !== p) begin
            errors++;
            $display("FAIL golden_idle got rdy=%b vld=%b pt=%h want 1 0 %h",
                     bus32.in_ready, bus32.out_valid, bus32.pt, p);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k;
        logic [63:0]  t, p;
        int           cyc;
        logic         bsy, rdy;
        k = {rand64(), rand64()};
        t = rand64();
        p = rand64();
        bus32.out_ready = 1'b0;
        start_job32(craft_enc(p, k, t, 32), k, t, cyc, bsy, rdy);
        bus32.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus32.pt !== p || bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got pt=%h vld=%b rdy=%b want %h 1 0",
                         i, bus32.pt, bus32.out_valid, bus32.in_ready, p);
            end
            @(negedge clk);
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.pt !== p) begin
            errors++;
            $display("FAIL release got rdy=%b vld=%b pt=%h want 1 0 %h",
                     bus32.in_ready, bus32.out_valid, bus32.pt, p);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  ps [NumJobs];
        logic [63:0]  cs [NumJobs];
        logic [127:0] ks [NumJobs];
        logic [63:0]  ts [NumJobs];
        logic [63:0]  expq [$];
        logic [63:0]  want;
        int           sent, recv, cyc, last;
        bit           load_next;
        for (int i = 0; i < NumJobs; i++) begin
            ps[i] = rand64();
            ks[i] = {rand64(), rand64()};
            ts[i] = rand64();
            cs[i] = craft_enc(ps[i], ks[i], ts[i], 32);
        end
        bus32.out_ready = 1'b1;
        bus32.ct        = cs[0];
        bus32.key       = ks[0];
        bus32.tweak     = ts[0];
        bus32.in_valid  = 1'b1;
        sent      = 0;
        recv      = 0;
        cyc       = 0;
        last      = -1;
        load_next = 1'b0;
        while (recv < NumJobs && cyc < NumJobs * 40) begin
            if (bus32.in_ready && bus32.in_valid) begin
                expq.push_back(ps[sent]);
                sent++;
                load_next = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (bus32.out_valid) begin
                want = (expq.size() > 0) ? expq.pop_front() : ~bus32.pt;
                checks++;
                if (bus32.pt !== want) begin
                    errors++;
                    $display("FAIL b2b_pt_%0d got %h want %h", recv, bus32.pt, want);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 34) begin
                        errors++;
                        $display("FAIL b2b_gap_%0d got %0d want 34", recv, cyc - last);
                    end
                end
                last = cyc;
                recv++;
            end
            if (load_next) begin
                load_next = 1'b0;
                if (sent < NumJobs) begin
                    bus32.ct    = cs[sent];
                    bus32.key   = ks[sent];
                    bus32.tweak = ts[sent];
                end else begin
                    bus32.in_valid = 1'b0;
                end
            end
        end
        bus32.in_valid = 1'b0;
        checks++;
        if (recv !== NumJobs) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", recv, NumJobs);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        logic [127:0] k;
        logic [63:0]  t, p;
        int           cyc;
        logic         bsy, rdy;
        k = {rand64(), rand64()};
        t = rand64();
        p = rand64();
        bus32.out_ready = 1'b1;
        bus32.ct        = craft_enc(p, k, t, 32);
        bus32.key       = k;
        bus32.tweak     = t;
        bus32.in_valid  = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0 ||
            bus32.pt !== 64'h0) begin
            errors++;
            $display("FAIL midjob_reset got rdy=%b vld=%b busy=%b pt=%h want 1 0 0 0",
                     bus32.in_ready, bus32.out_valid, bus32.busy, bus32.pt);
        end
        p = rand64();
        start_job32(craft_enc(p, k, t, 32), k, t, cyc, bsy, rdy);
        checks++;
        if (bus32.pt !== p || cyc !== 33) begin
            errors++;
            $display("FAIL midjob_next got pt=%h cyc=%0d want %h 33", bus32.pt, cyc, p);
        end
        @(negedge clk);
    endtask

    task automatic test_reduced_rounds();
        logic [127:0] k;
        logic [63:0]  t, p;
        int           cyc;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = {rand64(), rand64()};
            t = rand64();
            p = rand64();
            @(negedge clk);
            bus1.ct       = craft_enc(p, k, t, 1);
            bus1.key      = k;
            bus1.tweak    = t;
            bus1.in_valid = 1'b1;
            @(negedge clk);
            bus1.in_valid = 1'b0;
            cyc = 1;
            while (!bus1.out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus1.pt !== p || cyc !== 2) begin
                errors++;
                $display("FAIL reduced_%0d got pt=%h cyc=%0d want %h 2", i, bus1.pt, cyc, p);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.ct        = '0;
        bus32.key       = '0;
        bus32.tweak     = '0;
        bus32.out_ready = 1'b0;
        bus1.in_valid   = 1'b0;
        bus1.ct         = '0;
        bus1.key        = '0;
        bus1.tweak      = '0;
        bus1.out_ready  = 1'b0;
        test_reset();
        test_golden();
        test_backpressure();
        test_back_to_back();
        test_reset_midjob();
        test_reduced_rounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
